// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, round-constant table and key-schedule FSM states
// Contents:
//   NR          number of AES-128 rounds
//   rcon(idx)   round constant byte for idx 0..9 (returns 0 outside that range)
//   kx_state_e  state encoding for the key-schedule sequencers
package aes_pkg;

    localparam int NR = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READY = 2'd1,
        ST_BUSY  = 2'd2
    } kx_state_e;

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        logic [7:0] r;
        case (idx)
            4'd0:    r = 8'h01;
            4'd1:    r = 8'h02;
            4'd2:    r = 8'h04;
            4'd3:    r = 8'h08;
            4'd4:    r = 8'h10;
            4'd5:    r = 8'h20;
            4'd6:    r = 8'h40;
            4'd7:    r = 8'h80;
            4'd8:    r = 8'h1b;
            4'd9:    r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box
// Ports:
//   a  input byte
//   d  substituted byte: affine transform of the GF(2^8) multiplicative inverse of a
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] d
);

    // Multiplication in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] s;
        p = 8'h00;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) begin
                p = p ^ s;
            end
            s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (254 = 2+4+...+128); maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = gf_mul(x, x);
        r = p;
        for (int i = 2; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        d   = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    end

endmodule

// File: rtl/aes_inv_keyexpand128.sv
// rtl/aes_inv_keyexpand128.sv - AES-128 inverse key schedule, one S-box shared over 4 cycles per step
// Ports:
//   CLK, RSTn         clock, asynchronous active-low reset
//   ld, KEY           load KEY (round-10 key, word 0 in [127:96]) as the current key
//   step              regenerate the previous round key (accepted only when READY and round > 0)
//   Wk0..Wk3          current round-key words (register outputs)
//   round             round index of the current key, 10 down to 0
//   valid             key and round are stable
//   busy              a backward step is in progress
module aes_inv_keyexpand128
    import aes_pkg::*;
(
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         ld,
    input  logic [127:0] KEY,
    input  logic         step,
    output logic [31:0]  Wk0,
    output logic [31:0]  Wk1,
    output logic [31:0]  Wk2,
    output logic [31:0]  Wk3,
    output logic [3:0]   round,
    output logic         valid,
    output logic         busy
);

    kx_state_e   state_q, state_d;
    logic [31:0] w0_q, w0_d;
    logic [31:0] w1_q, w1_d;
    logic [31:0] w2_q, w2_d;
    logic [31:0] w3_q, w3_d;
    logic [3:0]  round_q, round_d;
    logic [1:0]  bcnt_q, bcnt_d;
    logic [31:0] subrot_q, subrot_d;

    logic [31:0] w3p;
    logic [7:0]  sbox_a;
    logic [7:0]  sbox_d;
    logic [31:0] subrot_full;
    logic [31:0] rcon_word;

    // Previous-round W3 depends only on the current (held) words, so it stays
    // stable across all four BUSY cycles.
    assign w3p = w3_q ^ w2_q;

    always_comb begin
        case (bcnt_q)
            2'd0:    sbox_a = w3p[7:0];
            2'd1:    sbox_a = w3p[15:8];
            2'd2:    sbox_a = w3p[23:16];
            default: sbox_a = w3p[31:24];
        endcase
    end

    aes_sbox u_sbox (
        .a (sbox_a),
        .d (sbox_d)
    );

    // Final byte comes straight from the S-box on the last BUSY cycle; it lands
    // in [7:0] because RotWord moves W3p byte 3 to the bottom.
    assign subrot_full = {subrot_q[31:8], sbox_d};
    assign rcon_word   = {rcon(round_q - 4'd1), 24'h000000};

    always_comb begin
        state_d  = state_q;
        w0_d     = w0_q;
        w1_d     = w1_q;
        w2_d     = w2_q;
        w3_d     = w3_q;
        round_d  = round_q;
        bcnt_d   = bcnt_q;
        subrot_d = subrot_q;

        case (state_q)
            ST_IDLE: begin
            end
            ST_READY: begin
                if (step && (round_q != 4'd0)) begin
                    state_d = ST_BUSY;
                    bcnt_d  = 2'd0;
                end
            end
            ST_BUSY: begin
                bcnt_d = bcnt_q + 2'd1;
                case (bcnt_q)
                    2'd0: subrot_d[15:8]  = sbox_d;
                    2'd1: subrot_d[23:16] = sbox_d;
                    2'd2: subrot_d[31:24] = sbox_d;
                    default: begin
                        subrot_d[7:0] = sbox_d;
                        w3_d    = w3p;
                        w2_d    = w2_q ^ w1_q;
                        w1_d    = w1_q ^ w0_q;
                        w0_d    = w0_q ^ subrot_full ^ rcon_word;
                        round_d = round_q - 4'd1;
                        state_d = ST_READY;
                    end
                endcase
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A load wins over everything, including a half-finished step.
        if (ld) begin
            w0_d    = KEY[127:96];
            w1_d    = KEY[95:64];
            w2_d    = KEY[63:32];
            w3_d    = KEY[31:0];
            round_d = 4'(NR);
            bcnt_d  = 2'd0;
            state_d = ST_READY;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q  <= ST_IDLE;
            w0_q     <= '0;
            w1_q     <= '0;
            w2_q     <= '0;
            w3_q     <= '0;
            round_q  <= '0;
            bcnt_q   <= '0;
            subrot_q <= '0;
        end else begin
            state_q  <= state_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            w2_q     <= w2_d;
            w3_q     <= w3_d;
            round_q  <= round_d;
            bcnt_q   <= bcnt_d;
            subrot_q <= subrot_d;
        end
    end

    assign Wk0   = w0_q;
    assign Wk1   = w1_q;
    assign Wk2   = w2_q;
    assign Wk3   = w3_q;
    assign round = round_q;
    assign valid = (state_q == ST_READY);
    assign busy  = (state_q == ST_BUSY);

endmodule

// File: tb/tb_aes_inv_keyexpand128.sv
// tb/tb_aes_inv_keyexpand128.sv - scoreboard bench for the AES-128 inverse key schedule
`timescale 1ns/1ps
module tb_aes_inv_keyexpand128;

    logic         CLK = 1'b0;
    logic         RSTn = 1'b0;
    logic         ld = 1'b0;
    logic [127:0] KEY = '0;
    logic         step = 1'b0;
    logic [31:0]  Wk0, Wk1, Wk2, Wk3;
    logic [3:0]   round;
    logic         valid;
    logic         busy;

    always #5 CLK = ~CLK;

    aes_inv_keyexpand128 dut (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .ld    (ld),
        .KEY   (KEY),
        .step  (step),
        .Wk0   (Wk0),
        .Wk1   (Wk1),
        .Wk2   (Wk2),
        .Wk3   (Wk3),
        .round (round),
        .valid (valid),
        .busy  (busy)
    );

    typedef struct packed {
        logic [127:0] key;
        logic [3:0]   rnd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [7:0] sbox_tab [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic [7:0] rcon_tab [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // FIPS-197 appendix A.1 round keys, index = round.
    logic [127:0] fips_rk [11] = '{
        128'h2b7e1516_28aed2a6_abf71588_09cf4f3c,
        128'ha0fafe17_88542cb1_23a33939_2a6c7605,
        128'hf2c295f2_7a96b943_5935807a_7359f67f,
        128'h3d80477d_4716fe3e_1e237e44_6d7a883b,
        128'hef44a541_a8525b7f_b671253b_db0bad00,
        128'hd4d1c6f8_7c839d87_caf2b8bc_11f915bc,
        128'h6d88a37a_110b3efd_dbf98641_ca0093fd,
        128'h4e54f70e_5f5fc9f3_84a64fb2_4ea6dc4f,
        128'head27321_b58dbad2_312bf560_7f8d292f,
        128'hac7766f3_19fadc21_28d12941_575c006e,
        128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6
    };

    logic [127:0] rnd_rk [11];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox_tab[r[31:24]], sbox_tab[r[23:16]], sbox_tab[r[15:8]], sbox_tab[r[7:0]]};
    endfunction

    task automatic fwd_expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) t = sub_rot(t) ^ {rcon_tab[i/4 - 1], 24'h0};
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) rnd_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Monitor: a new output is a rise of valid, or a change of key/round while valid.
    initial begin
        logic [131:0] prev;
        logic [131:0] cur;
        logic         pv;
        exp_t         e;
        prev = '0;
        pv   = 1'b0;
        forever begin
            @(negedge CLK);
            cur = {Wk0, Wk1, Wk2, Wk3, round};
            if (valid && (!pv || cur != prev)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL monitor_unexpected: got %h required none", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard_key_round", 160'(cur), 160'(e));
                end
            end
            pv   = valid;
            prev = cur;
        end
    end

    initial begin
        int           cnt;
        logic [127:0] key2;
        logic [127:0] rkey;

        #2;
        chk("reset_outputs", 160'({Wk0, Wk1, Wk2, Wk3, round}), 160'(0));
        chk("reset_flags", 160'({valid, busy}), 160'(0));
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;

        step = 1'b1;
        repeat (2) @(negedge CLK);
        step = 1'b0;
        chk("idle_step_ignored", 160'({valid, busy, round}), 160'(0));

        KEY = fips_rk[10];
        ld  = 1'b1;
        exp_q.push_back({fips_rk[10], 4'd10});
        @(negedge CLK);
        ld = 1'b0;
        chk("ld_valid", 160'({valid, busy}), 160'(2'b10));

        step = 1'b1;
        exp_q.push_back({fips_rk[9], 4'd9});
        @(negedge CLK);
        step = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("busy_window", 160'({valid, busy}), 160'(2'b01));
            @(negedge CLK);
        end
        chk("step_done", 160'({valid, busy, round}), 160'({2'b10, 4'd9}));

        for (int r = 8; r >= 0; r--) exp_q.push_back({fips_rk[r], 4'(r)});
        step = 1'b1;
        cnt  = 0;
        while (round !== 4'd0 && cnt < 200) begin
            @(posedge CLK);
            #1;
            cnt++;
        end
        chk("step_period", 160'(cnt), 160'(45));
        repeat (10) begin
            @(negedge CLK);
            chk("round0_step_ignored", 160'({busy, valid, Wk0, Wk1, Wk2, Wk3, round}),
                160'({2'b01, fips_rk[0], 4'd0}));
        end
        step = 1'b0;

        KEY = fips_rk[10];
        ld  = 1'b1;
        exp_q.push_back({fips_rk[10], 4'd10});
        @(negedge CLK);
        ld   = 1'b0;
        step = 1'b1;
        @(negedge CLK);
        step = 1'b0;
        key2 = 128'h00112233_44556677_8899aabb_ccddeeff;
        @(posedge CLK);
        #1;
        KEY = key2;
        ld  = 1'b1;
        exp_q.push_back({key2, 4'd10});
        @(posedge CLK);
        #1;
        ld = 1'b0;
        @(negedge CLK);
        chk("abandon_state", 160'({valid, busy, round}), 160'({2'b10, 4'd10}));
        repeat (6) @(negedge CLK);
        chk("abandon_stays", 160'({valid, busy, Wk0, Wk1, Wk2, Wk3, round}),
            160'({2'b10, key2, 4'd10}));

        step = 1'b1;
        @(posedge CLK);
        #1;
        step = 1'b0;
        @(posedge CLK);
        #2;
        RSTn = 1'b0;
        #1;
        chk("async_reset", 160'({valid, busy, Wk0, Wk1, Wk2, Wk3, round}), 160'(0));
        @(negedge CLK);
        RSTn = 1'b1;
        step = 1'b1;
        repeat (3) @(negedge CLK);
        step = 1'b0;
        chk("post_reset_idle", 160'({valid, busy, Wk0, Wk1, Wk2, Wk3, round}), 160'(0));

        for (int t = 0; t < 3; t++) begin
            rkey = {$urandom, $urandom, $urandom, $urandom};
            fwd_expand(rkey);
            KEY = rnd_rk[10];
            ld  = 1'b1;
            exp_q.push_back({rnd_rk[10], 4'd10});
            @(negedge CLK);
            ld = 1'b0;
            for (int r = 9; r >= 0; r--) exp_q.push_back({rnd_rk[r], 4'(r)});
            step = 1'b1;
            cnt  = 0;
            while (round !== 4'd0 && cnt < 100) begin
                @(negedge CLK);
                cnt++;
            end
            step = 1'b0;
            chk("random_in_time", 160'(cnt < 100), 160'(1));
            chk("random_cipher_key", 160'({Wk0, Wk1, Wk2, Wk3}), 160'(rkey));
        end

        repeat (5) @(negedge CLK);
        chk("queue_drained", 160'(exp_q.size()), 160'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
